// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
// Latency: none (declarations only).
// Backpressure: n/a; ob_has_room() is the read-issue throttle used by the top.
package ram_fifo_ctrl_pkg;

  // Output buffer depth: enough to cover one word in flight from the RAM
  // plus one word being presented downstream.
  localparam int OB_DEPTH = 2;

  typedef logic [1:0] ob_occ_t;

  // A read may be issued only if the word it returns is guaranteed a buffer
  // slot: words already buffered plus the one in flight, minus the one
  // leaving this cycle, must stay below the buffer depth.
  function automatic logic ob_has_room(input ob_occ_t occ,
                                       input logic    inflight,
                                       input logic    pop_fire);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = {1'b0, occ} + {2'b00, inflight};
    limit     = 3'(OB_DEPTH) + {2'b00, pop_fire};
    return committed < limit;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_outbuf.sv
// 2-entry register FIFO that absorbs RAM read data and presents a registered head.
// Latency: data written in cycle N is visible on out_data/out_valid in cycle N+1.
// Backpressure: no in_ready; the producer must never write when full (asserted).
// Ports: clk, rst_n, in_valid/in_data (write), out_valid/out_ready/out_data (read),
//        occ = number of entries held (0..2).
module ram_fifo_outbuf
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output ob_occ_t            occ
);

  logic [D_WIDTH-1:0] head;
  logic [D_WIDTH-1:0] tail;
  logic               pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  // head always holds the oldest entry so out_data comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (in_valid) begin
            head <= in_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          case ({in_valid, pop})
            2'b11:   head <= in_data;
            2'b10: begin
              tail <= in_data;
              occ  <= 2'd2;
            end
            2'b01:   occ <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (in_valid) tail <= in_data;
            else          occ  <= 2'd1;
          end
        end
      endcase
    end
  end

  // Writing into a full buffer without a simultaneous pop would drop a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_valid && occ == 2'd2 && !pop));

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 1W/1R registered-read RAM.
// Latency: push in cycle N -> read issue N+1 -> RAM data N+2 -> pop_valid N+3; 1 word/cycle steady state.
// Backpressure: push_ready from registered RAM occupancy only; pop side stalls hold head stable.
// Ports: clk, rst_n; push_valid/push_ready/push_data (upstream); pop_valid/pop_ready/pop_data
//        (downstream); ram_* (RAM write/read pins); count = RAM + in-flight + buffered words.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [D_WIDTH-1:0] push_data,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [D_WIDTH-1:0] pop_data,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  output logic [A_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam int PTR_W = A_WIDTH + 1;
  localparam int CNT_W = A_WIDTH + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             inflight;
  ob_occ_t          ob_occ;
  logic             push_fire;
  logic             pop_fire;
  logic             issue;

  assign ram_cnt    = wr_ptr - rd_ptr;
  assign push_ready = (ram_cnt != PTR_W'(DEPTH));
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  // ram_cnt is registered, so a word becomes readable only the cycle after
  // it is written: the RAM never sees a same-address read/write.
  assign issue = (ram_cnt != '0) & ob_has_room(ob_occ, inflight, pop_fire);

  assign ram_address_write = wr_ptr[A_WIDTH-1:0];
  assign ram_data_write    = push_data;
  assign ram_write_enable  = push_fire;
  assign ram_address_read  = rd_ptr[A_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue)     rd_ptr <= rd_ptr + PTR_W'(1);
      // Marks that ram_data_read carries a real word next cycle; cleared by
      // reset so stale RAM output after a mid-run reset is never captured.
      inflight <= issue;
      count    <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  ram_fifo_outbuf #(
    .D_WIDTH (D_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight),
    .in_data   (ram_data_read),
    .out_valid (pop_valid),
    .out_ready (pop_ready),
    .out_data  (pop_data),
    .occ       (ob_occ)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW-1:0] ram_address_write;
  logic [DW-1:0] ram_data_write;
  logic          ram_write_enable;
  logic [AW-1:0] ram_address_read;
  logic [DW-1:0] ram_data_read;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_data         (push_data),
    .pop_valid         (pop_valid),
    .pop_ready         (pop_ready),
    .pop_data          (pop_data),
    .ram_address_write (ram_address_write),
    .ram_data_write    (ram_data_write),
    .ram_write_enable  (ram_write_enable),
    .ram_address_read  (ram_address_read),
    .ram_data_read     (ram_data_read),
    .count             (count)
  );

  // Behavioural 1W/1R RAM with registered read, as the parent would provide.
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_data_read <= mem[ram_address_read];
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;

  logic          s_push_fire, s_pop_fire, s_pop_valid, s_push_ready;
  logic [DW-1:0] s_pop_data;
  logic [AW:0]   s_count;

  // One clock cycle: drive inputs, sample on the falling edge, record accepted
  // pushes in the scoreboard, then step past the rising edge.
  task automatic tick(input logic pv, input logic [DW-1:0] pd, input logic pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    @(negedge clk);
    s_push_ready = push_ready;
    s_pop_valid  = pop_valid;
    s_pop_data   = pop_data;
    s_count      = count;
    s_push_fire  = pv & push_ready;
    s_pop_fire   = pop_valid & pr;
    if (s_push_fire) exp_q.push_back(pd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (s_pop_valid !== 1'b0 || s_count !== '0) begin
        errors++;
        $display("FAIL reset_hold pop_valid=%b count=%0d required 0/0", s_pop_valid, s_count);
      end
    end
    exp_q.delete();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b0);
    checks++;
    if (s_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_push_ready got %b required 1", s_push_ready);
    end
    checks++;
    if (s_pop_data !== '0 || s_pop_valid !== 1'b0 || s_count !== '0) begin
      errors++;
      $display("FAIL reset_release pop_data=%h pop_valid=%b count=%0d required 0/0/0",
               s_pop_data, s_pop_valid, s_count);
    end
  endtask

  task automatic test_single();
    int first = -1;
    tick(1'b1, 16'hBEEF, 1'b1);
    checks++;
    if (s_push_fire !== 1'b1) begin
      errors++;
      $display("FAIL single_accept push_ready=%b required 1", s_push_ready);
    end
    for (int c = 1; c < 10; c++) begin
      tick(1'b0, '0, 1'b1);
      if (s_pop_valid && first < 0) first = c;
      if (s_pop_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL single_underflow got %h required none", s_pop_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (s_pop_data !== exp_w) begin
            errors++;
            $display("FAIL single_data got %h required %h", s_pop_data, exp_w);
          end
        end
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL single_latency first pop_valid cycle %0d required 3", first);
    end
    checks++;
    if (s_count !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count count=%0d left=%0d required 0/0", s_count, exp_q.size());
    end
  endtask

  task automatic test_fill();
    int accepted = 0;
    for (int v = 0; v <= 40; v++) begin
      tick(1'b1, DW'(v), 1'b0);
      if (s_push_fire) accepted++;
    end
    checks++;
    if (accepted != 34) begin
      errors++;
      $display("FAIL fill_accepted got %0d required 34", accepted);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
    checks++;
    if (s_push_ready !== 1'b0 || s_count !== 6'd34) begin
      errors++;
      $display("FAIL fill_full push_ready=%b count=%0d required 0/34", s_push_ready, s_count);
    end
    checks++;
    if (s_pop_valid !== 1'b1 || s_pop_data !== 16'd0) begin
      errors++;
      $display("FAIL fill_head pop_valid=%b pop_data=%h required 1/0000", s_pop_valid, s_pop_data);
    end
  endtask

  task automatic test_drain();
    int pops = 0, first = -1, gaps = 0;
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      tick(1'b0, '0, 1'b1);
      if (s_pop_fire) begin
        pops++;
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL drain_underflow got %h required none", s_pop_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (s_pop_data !== exp_w) begin
            errors++;
            $display("FAIL drain_data got %h required %h", s_pop_data, exp_w);
          end
        end
      end else if (first >= 0) begin
        gaps++;
      end
    end
    checks++;
    if (pops != 34 || gaps != 0) begin
      errors++;
      $display("FAIL drain_count pops=%0d gaps=%0d required 34/0", pops, gaps);
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (s_pop_valid !== 1'b0 || s_count !== '0) begin
      errors++;
      $display("FAIL drain_empty pop_valid=%b count=%0d required 0/0", s_pop_valid, s_count);
    end
  endtask

  task automatic test_stream();
    int sent = 0, pops = 0, first = -1, gaps = 0, stalls = 0;
    logic pv;
    for (int c = 0; c < 400 && pops < 200; c++) begin
      pv = (sent < 200);
      tick(pv, DW'(16'h1000 + sent), 1'b1);
      if (pv && s_push_fire) sent++;
      else if (pv) stalls++;
      if (s_pop_fire) begin
        pops++;
        if (first < 0) first = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_underflow got %h required none", s_pop_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (s_pop_data !== exp_w) begin
            errors++;
            $display("FAIL stream_data got %h required %h", s_pop_data, exp_w);
          end
        end
      end else if (first >= 0) begin
        gaps++;
      end
    end
    checks++;
    if (pops != 200 || gaps != 0 || stalls != 0 || first != 3) begin
      errors++;
      $display("FAIL stream_rate pops=%0d gaps=%0d stalls=%0d first=%0d required 200/0/0/3",
               pops, gaps, stalls, first);
    end
  endtask

  task automatic test_random();
    logic          pr;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            exp_cnt;
    for (int c = 0; c < 5000; c++) begin
      if (c == 2500) begin
        rst_n = 1'b0;
        exp_q.delete();
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (s_pop_valid !== 1'b0 || s_count !== '0) begin
          errors++;
          $display("FAIL random_reset pop_valid=%b count=%0d required 0/0", s_pop_valid, s_count);
        end
        rst_n = 1'b1;
        prev_stall = 1'b0;
        continue;
      end
      pr = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), DW'($urandom), pr);
      exp_cnt = exp_q.size() - int'(s_push_fire);
      checks++;
      if (int'(s_count) != exp_cnt) begin
        errors++;
        $display("FAIL random_count cycle %0d got %0d required %0d", c, s_count, exp_cnt);
      end
      if (prev_stall) begin
        checks++;
        if (s_pop_valid !== 1'b1 || s_pop_data !== prev_data) begin
          errors++;
          $display("FAIL random_hold pop_valid=%b pop_data=%h required 1/%h",
                   s_pop_valid, s_pop_data, prev_data);
        end
      end
      prev_stall = s_pop_valid & ~pr;
      prev_data  = s_pop_data;
      if (s_pop_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_underflow got %h required none", s_pop_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (s_pop_data !== exp_w) begin
            errors++;
            $display("FAIL random_data cycle %0d got %h required %h", c, s_pop_data, exp_w);
          end
        end
      end
    end
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      tick(1'b0, '0, 1'b1);
      if (s_pop_fire) begin
        checks++;
        exp_w = exp_q.pop_front();
        if (s_pop_data !== exp_w) begin
          errors++;
          $display("FAIL random_drain got %h required %h", s_pop_data, exp_w);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain_timeout left %0d required 0", exp_q.size());
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (s_pop_valid !== 1'b0 || s_count !== '0) begin
      errors++;
      $display("FAIL random_final pop_valid=%b count=%0d required 0/0", s_pop_valid, s_count);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
